apb_cmd_sequencer: RTL and testbench

Upstream command stage for the APB master subsystem. Accepts a queue of read/write commands over a valid/ready interface and buffers them in a FIFO. Replays each command onto the master's TRANSFER/write/read request pins, one at a time. Detects completion from PENABLE/pready1, captures the read data and error status, and returns one response per command over a valid/ready response channel.

---
 rtl/apb_cmd_sequencer_if.sv | 49 ++++
 rtl/apb_cmd_sequencer.sv | 115 +++++++++++
 tb/tb_apb_cmd_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_sequencer_if.sv
// apb_cmd_sequencer_if: command/response channels and APB master request pins for apb_cmd_sequencer.
// Stats outputs exist only when APB_SEQ_STATS_EN is defined.
interface apb_cmd_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              TRANSFER;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] apb_write_address;
  logic [DATA_W-1:0] apb_write_data;
  logic [ADDR_W-1:0] apb_read_address;
  logic              PENABLE;
  logic              pready1;
  logic              PSLVERR;
  logic [DATA_W-1:0] apb_read_out;
`ifdef APB_SEQ_STATS_EN
  logic [15:0]       stat_done;
  logic [15:0]       stat_err;
`endif
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           PENABLE, pready1, PSLVERR, apb_read_out,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           TRANSFER, write, read, apb_write_address, apb_write_data, apb_read_address
`ifdef APB_SEQ_STATS_EN
    , output stat_done, stat_err
`endif
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           PENABLE, pready1, PSLVERR, apb_read_out,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           TRANSFER, write, read, apb_write_address, apb_write_data, apb_read_address
`ifdef APB_SEQ_STATS_EN
    , input stat_done, stat_err
`endif
  );
endinterface

// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer: FIFO-buffered command replay onto APB master request pins, one response per command.
// Optional APB_SEQ_STATS_EN adds saturating response/error counters.
module apb_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic PCLK,
  input logic PRESET,
  apb_cmd_sequencer_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;
  cmd_t              mem_q [DEPTH];
  cmd_t              cmd_q, cmd_d;
  state_t            st_q, st_d;
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [CW-1:0]     tmo_q, tmo_d;
  logic              rsp_write_q, rsp_write_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              ready, push, pop, done, active;
  always_comb begin
    ready  = cnt_q != (PW+1)'(DEPTH);
    push   = bus.cmd_valid && ready;
    pop    = st_q == IDLE && cnt_q != '0;
    done   = bus.PENABLE && bus.pready1;
    wp_d   = wp_q + PW'(push);
    rp_d   = rp_q + PW'(pop);
    cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    cmd_d  = pop ? mem_q[rp_q] : cmd_q;
    st_d   = st_q;
    tmo_d  = tmo_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (st_q)
      IDLE:  st_d = pop ? ISSUE : IDLE;
      ISSUE: st_d = WAIT;
      WAIT: begin
        if (done || tmo_q == CW'(TIMEOUT-1)) begin
          st_d        = RESP;
          rsp_write_d = cmd_q.wr;
          rsp_err_d   = done ? bus.PSLVERR : 1'b1;
          rsp_rdata_d = (done && !cmd_q.wr) ? bus.apb_read_out : '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        st_d  = bus.rsp_ready ? IDLE : RESP;
        tmo_d = bus.rsp_ready ? '0 : tmo_q;
      end
    endcase
    active = st_q == ISSUE || st_q == WAIT;
  end
  assign bus.cmd_ready         = ready;
  assign bus.rsp_valid         = st_q == RESP;
  assign bus.rsp_write         = rsp_write_q;
  assign bus.rsp_err           = rsp_err_q;
  assign bus.rsp_rdata         = rsp_rdata_q;
  assign bus.TRANSFER          = active;
  assign bus.write             = active && cmd_q.wr;
  assign bus.read              = active && !cmd_q.wr;
  assign bus.apb_write_address = (active && cmd_q.wr) ? cmd_q.addr : '0;
  assign bus.apb_write_data    = (active && cmd_q.wr) ? cmd_q.data : '0;
  assign bus.apb_read_address  = (active && !cmd_q.wr) ? cmd_q.addr : '0;
  always_ff @(posedge PCLK)
    if (push) mem_q[wp_q] <= cmd_t'({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata});
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      st_q        <= IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      cmd_q       <= '0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      st_q        <= st_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      cmd_q       <= cmd_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
`ifdef APB_SEQ_STATS_EN
  logic [15:0] sd_q, sd_d, se_q, se_d;
  logic        hs;
  always_comb begin
    hs   = st_q == RESP && bus.rsp_ready;
    sd_d = (hs && sd_q != '1) ? sd_q + 1'b1 : sd_q;
    se_d = (hs && rsp_err_q && se_q != '1) ? se_q + 1'b1 : se_q;
  end
  always_ff @(posedge PCLK) begin
    sd_q <= PRESET ? '0 : sd_d;
    se_q <= PRESET ? '0 : se_d;
  end
  assign bus.stat_done = sd_q;
  assign bus.stat_err  = se_q;
`endif
endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// tb_apb_cmd_sequencer: directed + randomized checks of apb_cmd_sequencer against a command-queue reference model.
module tb_apb_cmd_sequencer;
  localparam int TIMEOUT = 16;
  logic PCLK = 0;
  logic PRESET;
  int n_chk = 0, n_fail = 0;
  int exp_done = 0, exp_err = 0;
  typedef struct {logic wr; logic [31:0] a; logic [31:0] d;} cmd_t;
  cmd_t exp_q[$];
  always #5 PCLK = ~PCLK;
  apb_cmd_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  apb_cmd_sequencer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus)
  );
  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_chk++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask
  task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.wr = wr; c.a = a; c.d = d;
    bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_wdata = d;
    if (bus.cmd_ready === 1'b1) exp_q.push_back(c);
    tick;
    bus.cmd_valid = 0; bus.cmd_write = 1'($urandom); bus.cmd_addr = $urandom; bus.cmd_wdata = $urandom;
  endtask
  // w = number of WAIT cycles before completion is offered; w >= TIMEOUT means it never arrives in time
  task automatic serve(input int w, input logic [31:0] rd, input logic er, input bit chk_len);
    cmd_t c;
    int n, r;
    bit tmo;
    logic [31:0] erd;
    logic eer;
    n = 0;
    while (bus.TRANSFER !== 1'b1 && n < 40) begin tick; n++; end
    chk("issue_seen", bus.TRANSFER, 1);
    c.wr = 0; c.a = 0; c.d = 0;
    if (exp_q.size() > 0) c = exp_q.pop_front();
    n = 0;
    while (bus.TRANSFER === 1'b1 && n < 60) begin
      chk("req_write", bus.write, c.wr);
      chk("req_read", bus.read, !c.wr);
      chk("req_wr_addr", bus.apb_write_address, c.wr ? c.a : 32'h0);
      chk("req_wr_data", bus.apb_write_data, c.wr ? c.d : 32'h0);
      chk("req_rd_addr", bus.apb_read_address, c.wr ? 32'h0 : c.a);
      if (n == w + 1) begin
        bus.PENABLE = 1; bus.pready1 = 1; bus.apb_read_out = rd; bus.PSLVERR = er;
      end else begin
        r = $urandom_range(0, 2);
        bus.PENABLE = (r == 1); bus.pready1 = (r == 2);
        bus.apb_read_out = $urandom; bus.PSLVERR = 1'($urandom);
      end
      tick;
      n++;
    end
    bus.PENABLE = 0; bus.pready1 = 0;
    tmo = (w >= TIMEOUT);
    erd = (tmo || c.wr) ? 32'h0 : rd;
    eer = tmo ? 1'b1 : er;
    if (chk_len) chk("xfer_len", n, tmo ? TIMEOUT + 1 : w + 2);
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_write", bus.rsp_write, c.wr);
    chk("rsp_rdata", bus.rsp_rdata, erd);
    chk("rsp_err", bus.rsp_err, eer);
    chk("resp_write_low", bus.write, 0);
    chk("resp_read_low", bus.read, 0);
    repeat ($urandom_range(0, 3)) begin
      tick;
      chk("rsp_hold_valid", bus.rsp_valid, 1);
      chk("rsp_hold_rdata", bus.rsp_rdata, erd);
      chk("rsp_hold_err", bus.rsp_err, eer);
    end
    bus.rsp_ready = 1;
    tick;
    bus.rsp_ready = 0;
    exp_done++;
    if (eer) exp_err++;
    chk("rsp_consumed", bus.rsp_valid, 0);
`ifdef APB_SEQ_STATS_EN
    chk("stat_done", bus.stat_done, exp_done);
    chk("stat_err", bus.stat_err, exp_err);
`endif
  endtask
  initial begin
    int n, k;
    PRESET = 1;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
    bus.rsp_ready = 0; bus.PENABLE = 0; bus.pready1 = 0; bus.PSLVERR = 0; bus.apb_read_out = 0;
    repeat (2) tick;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_transfer", bus.TRANSFER, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_write", bus.write, 0);
    chk("rst_read", bus.read, 0);
    chk("rst_wr_addr", bus.apb_write_address, 0);
    chk("rst_rd_addr", bus.apb_read_address, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    PRESET = 0;
    tick;
    push(1, 32'h10, 32'hDEADBEEF);
    chk("lat_edge1", bus.TRANSFER, 0);
    tick;
    chk("lat_edge2", bus.TRANSFER, 1);
    serve(2, 32'h0, 0, 1);
    push(0, 32'h10, 32'h0);
    serve(1, 32'hDEADBEEF, 0, 1);
    push(0, 32'h24, 32'h0);
    serve(3, 32'hCAFE0001, 1, 1);
    push(1, 32'h30, 32'h5);
    serve(TIMEOUT - 1, 32'h0, 0, 1);
    push(0, 32'h40, 32'h0);
    push(1, 32'h44, 32'h77);
    serve(TIMEOUT, 32'h1234, 0, 1);
    serve(0, 32'h0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      chk("fill_ready", bus.cmd_ready, 1);
      push(1'($urandom), 32'h100 + 32'(i * 4), $urandom);
    end
    chk("full_ready", bus.cmd_ready, 0);
    push(1, 32'hBAD, 32'hBAD);
    chk("full_reject", bus.cmd_ready, 0);
    for (int i = 0; i < 5; i++) serve(i == 0 ? 0 : $urandom_range(0, 5), $urandom, 1'($urandom), i != 0);
    repeat (5) begin
      tick;
      chk("drained_xfer", bus.TRANSFER, 0);
      chk("drained_rsp", bus.rsp_valid, 0);
    end
    push(1, 32'h200, 32'h1);
    push(0, 32'h204, 32'h0);
    push(1, 32'h208, 32'h2);
    chk("pre_rst_xfer", bus.TRANSFER, 1);
    tick;
    PRESET = 1;
    tick;
    PRESET = 0;
    exp_q.delete();
`ifdef APB_SEQ_STATS_EN
    exp_done = 0; exp_err = 0;
`endif
    chk("midrst_xfer", bus.TRANSFER, 0);
    chk("midrst_rsp", bus.rsp_valid, 0);
    chk("midrst_ready", bus.cmd_ready, 1);
    n = 0;
    repeat (20) begin
      tick;
      if (bus.TRANSFER !== 1'b0 || bus.rsp_valid !== 1'b0) n++;
    end
    chk("midrst_quiet", n, 0);
    repeat (20) begin
      k = $urandom_range(1, 3);
      repeat (k) push(1'($urandom), $urandom, $urandom);
      for (int i = 0; i < k; i++)
        serve(i == 0 ? $urandom_range(0, 12) : $urandom_range(0, 17), $urandom, 1'($urandom), i != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
